// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT multiply/divide unit.
package rat_pkg;

  localparam int MD_ITERS = 8;
  localparam int MD_CNT_W = $clog2(MD_ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_t;

endpackage

// File: rtl/mul_div_datapath.sv
// Operand, accumulator and result registers for the iterative shift-add
// multiply and restoring divide. The accumulator holds {upper, lower} halves:
// MUL: {partial product, remaining multiplier bits}
// DIV: {remainder, dividend bits shifting into quotient}
module mul_div_datapath
  import rat_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             div0_load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  md_op_t           op,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div0
);

  md_op_t             op_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  // One multiply or divide iteration, computed from the current accumulator.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    acc_next = acc;
    if (op_r == OP_MUL) begin
      // The 9-bit sum keeps the carry, which becomes the new MSB after the shift.
      if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      // Remainder stays below the divisor, so both branches fit in WIDTH bits.
      if (rem_sh >= {1'b0, opnd}) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture on accept, one iteration per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= OP_MUL;
      opnd <= '0;
      acc  <= '0;
    end else if (load) begin
      op_r <= op;
      opnd <= (op == OP_MUL) ? a : b;
      acc  <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
    end else if (step) begin
      acc <= acc_next;
    end
  end

  // Results change only on completion; the final iteration is folded in directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_hi <= '0;
      result_lo <= '0;
      div0      <= 1'b0;
    end else if (finish) begin
      result_hi <= acc_next[2*WIDTH-1:WIDTH];
      result_lo <= acc_next[WIDTH-1:0];
      div0      <= 1'b0;
    end else if (div0_load) begin
      result_hi <= acc[WIDTH-1:0];
      result_lo <= '1;
      div0      <= 1'b1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: controller FSM with iteration counter,
// driving mul_div_datapath. Divide by zero skips RUN and reports one cycle
// after accept via a pending flag held in DONE (DONE output masked meanwhile).
//
// state | meaning
// IDLE  | waiting for START
// RUN   | one iteration per cycle, MD_ITERS cycles
// DONE  | result valid, DONE pulses (after div0 pending cycle if any)
module mul_div_unit
  import rat_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             OP,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic [WIDTH-1:0] RESULT_LO,
  output logic             DIV0
);

  md_state_t             state;
  md_state_t             state_nxt;
  logic [MD_CNT_W-1:0]   cnt;
  logic                  pend;
  logic                  load;
  logic                  step;
  logic                  finish;
  logic                  div0_load;
  logic                  is_div0;
  logic                  last;

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    div0_load = 1'b0;
    is_div0   = OP && (B == '0);
    last      = (cnt == MD_CNT_W'(MD_ITERS - 1));
    case (state)
      rat_pkg::IDLE, rat_pkg::DONE: begin
        if (pend) begin
          div0_load = 1'b1;
          state_nxt = rat_pkg::DONE;
        end else if (START) begin
          load      = 1'b1;
          state_nxt = is_div0 ? rat_pkg::DONE : rat_pkg::RUN;
        end else begin
          state_nxt = rat_pkg::IDLE;
        end
      end
      rat_pkg::RUN: begin
        step = 1'b1;
        if (last) begin
          finish    = 1'b1;
          state_nxt = rat_pkg::DONE;
        end
      end
      default: state_nxt = rat_pkg::IDLE;
    endcase
  end

  // State register, iteration counter and divide-by-zero pending flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= rat_pkg::IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= load && is_div0;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + MD_CNT_W'(1);
    end
  end

  assign BUSY = (state == rat_pkg::RUN);
  assign DONE = (state == rat_pkg::DONE) && !pend;

  mul_div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .div0_load (div0_load),
    .a         (A),
    .b         (B),
    .op        (md_op_t'(OP)),
    .result_hi (RESULT_HI),
    .result_lo (RESULT_LO),
    .div0      (DIV0)
  );

endmodule
